// File: rtl/led_share_arbiter_pkg.sv
// Shared types and constants for the RGB LED sharing arbiter.
package led_share_arbiter_pkg;

  localparam int DEFAULT_CLK_FREQ = 12_000_000;
  localparam logic LED_OFF = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    GAP
  } arb_state_t;

endpackage

// File: rtl/led_share_arbiter_if.sv
// Client-side bundle: per-client requests and colours in, grant and busy out.
interface led_share_arbiter_if #(
  parameter int NUM_REQ  = 3,
  parameter int PWM_BITS = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*3*PWM_BITS-1:0] color;
  logic [NUM_REQ-1:0]            gnt;
  logic                          busy;

  modport master (output req, output color, input gnt, input busy);
  modport slave  (input req, input color, output gnt, output busy);
endinterface

// File: rtl/led_share_arbiter_pwm.sv
// Three-channel PWM with duties latched only at the period boundary and registered active-low pins.
module led_share_arbiter_pwm
  import led_share_arbiter_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3*PWM_BITS-1:0] duty_in,
  output logic                  pin_r,
  output logic                  pin_g,
  output logic                  pin_b
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;
  logic                wrap;

  assign wrap = (pwm_cnt == {PWM_BITS{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty_r  <= '0;
      duty_g  <= '0;
      duty_b  <= '0;
      pin_r   <= LED_OFF;
      pin_g   <= LED_OFF;
      pin_b   <= LED_OFF;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      // Loading only on the last count keeps every period a single clean duty.
      if (wrap) begin
        duty_r <= duty_in[2*PWM_BITS +: PWM_BITS];
        duty_g <= duty_in[PWM_BITS +: PWM_BITS];
        duty_b <= duty_in[0 +: PWM_BITS];
      end
      pin_r <= (pwm_cnt < duty_r) ? ~LED_OFF : LED_OFF;
      pin_g <= (pwm_cnt < duty_g) ? ~LED_OFF : LED_OFF;
      pin_b <= (pwm_cnt < duty_b) ? ~LED_OFF : LED_OFF;
    end
  end

endmodule

// File: rtl/led_share_arbiter.sv
// Round-robin owner of the board RGB LED with minimum hold time and a one-cycle gap between owners.
module led_share_arbiter
  import led_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int CLK_FREQ    = DEFAULT_CLK_FREQ,
  parameter int HOLD_CYCLES = CLK_FREQ / 6,
  parameter int PWM_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  led_share_arbiter_if.slave  bus,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int CW = 3 * PWM_BITS;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  typedef logic [OW-1:0] idx_t;

  arb_state_t          state, state_nx;
  idx_t                owner, owner_nx;
  idx_t                rr_last, rr_last_nx;
  logic [HW-1:0]       hold_cnt, hold_nx;
  logic [NUM_REQ-1:0]  gnt_q, gnt_nx;
  logic                busy_q, busy_nx;
  logic [NUM_REQ-1:0]  owner_mask;
  logic                any_req, others_req;
  idx_t                base, winner;
  logic [CW-1:0]       owner_color, duty_in;

  // First requester strictly after 'last', wrapping; 'last' itself is lowest priority.
  function automatic idx_t rr_pick(input idx_t last, input logic [NUM_REQ-1:0] r);
    idx_t pick;
    logic found;
    int   idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && r[idx]) begin
        pick  = idx_t'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign owner_mask = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
  assign any_req    = |bus.req;
  assign others_req = |(bus.req & ~owner_mask);
  assign base       = (state == GAP) ? owner : rr_last;
  assign winner     = rr_pick(base, bus.req);

  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    rr_last_nx = rr_last;
    hold_nx    = hold_cnt;
    case (state)
      IDLE: begin
        hold_nx = '0;
        if (any_req) begin
          state_nx = OWNED;
          owner_nx = winner;
        end
      end
      OWNED: begin
        if (hold_cnt != HOLD_MAX) hold_nx = hold_cnt + HW'(1);
        if (!bus.req[owner] || (hold_cnt == HOLD_MAX && others_req)) state_nx = GAP;
      end
      GAP: begin
        hold_nx    = '0;
        rr_last_nx = owner;
        if (any_req) begin
          state_nx = OWNED;
          owner_nx = winner;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Grant and busy are computed from the next state so both leave a flop directly.
    gnt_nx  = (state_nx == OWNED) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_nx) : '0;
    busy_nx = (state_nx == OWNED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= idx_t'(NUM_REQ - 1);
      rr_last  <= idx_t'(NUM_REQ - 1);
      hold_cnt <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      rr_last  <= rr_last_nx;
      hold_cnt <= hold_nx;
      gnt_q    <= gnt_nx;
      busy_q   <= busy_nx;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;

  assign owner_color = bus.color[owner*CW +: CW];
  assign duty_in     = (state == OWNED) ? owner_color : '0;

  led_share_arbiter_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .duty_in(duty_in),
    .pin_r  (RGB_R),
    .pin_g  (RGB_G),
    .pin_b  (RGB_B)
  );

endmodule

// File: tb/tb_led_share_arbiter.sv
// Bench for led_share_arbiter: directed vector table, PWM sequences and random traffic against an ownership model.
module tb_led_share_arbiter;

  localparam int NR = 3;
  localparam int PB = 4;
  localparam int H  = 16;
  localparam int CW = 3 * PB;
  localparam int PERIOD = 1 << PB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rgb_r, rgb_g, rgb_b;

  always #5 clk = ~clk;

  led_share_arbiter_if #(.NUM_REQ(NR), .PWM_BITS(PB)) bus ();

  led_share_arbiter #(
    .NUM_REQ(NR),
    .HOLD_CYCLES(H),
    .PWM_BITS(PB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .RGB_R(rgb_r),
    .RGB_G(rgb_g),
    .RGB_B(rgb_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: who owns the LED (-1 = nobody), how long, and what each colour channel shows.
  int m_owner, m_last, m_held, m_cnt;
  bit m_gap;
  int m_duty[3];
  bit m_pin[3];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int chan(input int client, input int ch);
    logic [NR*CW-1:0] c;
    c = bus.color;
    return int'((c >> (client * CW + (2 - ch) * PB)) & {{(NR*CW-PB){1'b0}}, {PB{1'b1}}});
  endfunction

  function automatic int pick(input int last, input logic [NR-1:0] r);
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (last + k) % NR;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [NR-1:0] r;
    bit others;
    r = bus.req;
    if (!rst_n) begin
      m_owner = -1; m_last = NR - 1; m_held = 0; m_gap = 0; m_cnt = 0;
      for (int c = 0; c < 3; c++) begin m_duty[c] = 0; m_pin[c] = 1; end
    end else begin
      for (int c = 0; c < 3; c++) m_pin[c] = !(m_cnt < m_duty[c]);
      if (m_cnt == PERIOD - 1)
        for (int c = 0; c < 3; c++) m_duty[c] = (m_owner >= 0) ? chan(m_owner, c) : 0;
      m_cnt = (m_cnt + 1) % PERIOD;
      if (m_owner >= 0) begin
        others = (r & ~(NR'(1) << m_owner)) != 0;
        if (!r[m_owner] || (m_held >= H - 1 && others)) begin
          m_last = m_owner; m_owner = -1; m_gap = 1;
        end else begin
          m_held++;
        end
      end else if (m_gap) begin
        m_gap = 0; m_owner = pick(m_last, r); m_held = 0;
      end else begin
        m_owner = pick(m_last, r); m_held = 0;
      end
    end
  endtask

  task automatic tick();
    int eg;
    @(posedge clk);
    model_step();
    #1;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    check("gnt", int'(bus.gnt), eg);
    check("busy", int'(bus.busy), (m_owner >= 0) ? 1 : 0);
    check("rgb", int'({rgb_r, rgb_g, rgb_b}), int'({m_pin[0], m_pin[1], m_pin[2]}));
    check("onehot", ($countones(bus.gnt) <= 1) ? 1 : 0, 1);
  endtask

  typedef struct {
    bit           rst;
    logic [NR-1:0] req;
    int           cycles;
    logic [NR-1:0] g;
    bit           b;
  } vec_t;

  vec_t vt[$];

  initial begin
    int lr, lg, lb, waited;
    bus.req   = '0;
    bus.color = {12'h3C0, 12'hF08, 12'h888};

    vt.push_back('{0, 3'b111, 3,   3'b000, 0});
    vt.push_back('{1, 3'b111, 1,   3'b001, 1});
    vt.push_back('{1, 3'b111, 15,  3'b001, 1});
    vt.push_back('{1, 3'b111, 1,   3'b000, 0});
    vt.push_back('{1, 3'b111, 1,   3'b010, 1});
    vt.push_back('{1, 3'b111, 15,  3'b010, 1});
    vt.push_back('{1, 3'b111, 1,   3'b000, 0});
    vt.push_back('{1, 3'b111, 1,   3'b100, 1});
    vt.push_back('{0, 3'b000, 2,   3'b000, 0});
    vt.push_back('{1, 3'b101, 1,   3'b001, 1});
    vt.push_back('{1, 3'b101, 3,   3'b001, 1});
    vt.push_back('{1, 3'b100, 1,   3'b000, 0});
    vt.push_back('{1, 3'b100, 1,   3'b100, 1});
    vt.push_back('{1, 3'b001, 1,   3'b000, 0});
    vt.push_back('{1, 3'b001, 1,   3'b001, 1});
    vt.push_back('{1, 3'b001, 200, 3'b001, 1});
    vt.push_back('{1, 3'b011, 1,   3'b000, 0});
    vt.push_back('{1, 3'b011, 1,   3'b010, 1});
    vt.push_back('{1, 3'b101, 1,   3'b000, 0});
    vt.push_back('{1, 3'b101, 1,   3'b100, 1});

    foreach (vt[i]) begin
      rst_n   = vt[i].rst;
      bus.req = vt[i].req;
      repeat (vt[i].cycles) tick();
      check($sformatf("tbl%0d_gnt", i), int'(bus.gnt), int'(vt[i].g));
      check($sformatf("tbl%0d_busy", i), int'(bus.busy), int'(vt[i].b));
    end

    // Single owner PWM shape: colour {F,0,8}.
    rst_n = 0; bus.req = '0;
    repeat (2) tick();
    check("rst_rgb", int'({rgb_r, rgb_g, rgb_b}), 7);
    rst_n = 1; bus.req = 3'b010;
    tick();
    check("single_gnt", int'(bus.gnt), 2);
    repeat (40) tick();
    lr = 0; lg = 0; lb = 0;
    repeat (PERIOD) begin
      tick();
      lr += (rgb_r == 1'b0); lg += (rgb_g == 1'b0); lb += (rgb_b == 1'b0);
    end
    check("pwm_r_low", lr, 15);
    check("pwm_g_low", lg, 0);
    check("pwm_b_low", lb, 8);

    // Colour change in the middle of a period, then reset during ownership.
    waited = 0;
    while (m_cnt != 5 && waited < 2 * PERIOD) begin tick(); waited++; end
    check("midperiod_reached", (m_cnt == 5) ? 1 : 0, 1);
    bus.color[CW +: CW] = 12'h2F0;
    repeat (30) tick();
    lr = 0; lg = 0; lb = 0;
    repeat (PERIOD) begin
      tick();
      lr += (rgb_r == 1'b0); lg += (rgb_g == 1'b0); lb += (rgb_b == 1'b0);
    end
    check("newcol_r_low", lr, 2);
    check("newcol_g_low", lg, 15);
    check("newcol_b_low", lb, 0);
    rst_n = 0;
    tick();
    check("midown_rst_rgb", int'({rgb_r, rgb_g, rgb_b}), 7);
    check("midown_rst_gnt", int'(bus.gnt), 0);
    rst_n = 1;

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) bus.req = NR'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0)
        bus.color[$urandom_range(0, NR - 1) * CW +: CW] = CW'($urandom);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
